fft_bin_capture: RTL

//  Receiving end of the FFT output stream (re/im/valid/last from the 256-pt radix-2 DIT FFT).

---
 rtl/fft_bin_capture.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/fft_bin_capture.sv
// fft_bin_capture
// Receives the FFT output stream, captures complete frames into a two-bank
// ping-pong buffer and serves random-access bin reads to the MVDR stage.
// Frame framing (s_last vs. bin count) is checked, and frames that arrive
// while both banks are held are dropped and flagged.
//
// Ports
//   clk, rst            system clock (rising edge), async active-high reset
//   s_re, s_im          FFT bin, signed DW bits each
//   s_valid, s_last     bin strobe and last-bin marker (no backpressure)
//   frame_ready         read bank holds a complete frame
//   rd_en, rd_addr      bin read request; data returns one cycle later
//   rd_re, rd_im        read data (zero while rd_valid is low)
//   rd_valid            read data strobe
//   rd_release          reader done with the read bank
//   overrun             1-cycle pulse: incoming frame dropped
//   sync_err            1-cycle pulse: s_last misaligned with bin count
//
// Build option BIN_CAPTURE_PEAK_EN adds peak_bin / peak_mag2: the largest
// re*re+im*im bin of the frame in the read bank (lowest bin on ties), zero
// while frame_ready is low.
//
// Write FSM
//   state  | meaning
//   W_FILL | storing beats of the current frame (or idle between frames)
//   W_DROP | both banks were held at the first beat; discard until s_last

module fft_bin_capture #(
    parameter int N    = 256,
    parameter int DW   = 16,
    parameter int LOGN = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   s_re,
    input  logic [DW-1:0]   s_im,
    input  logic            s_valid,
    input  logic            s_last,
    output logic            frame_ready,
    input  logic            rd_en,
    input  logic [LOGN-1:0] rd_addr,
    output logic [DW-1:0]   rd_re,
    output logic [DW-1:0]   rd_im,
    output logic            rd_valid,
    input  logic            rd_release,
    output logic            overrun,
    output logic            sync_err
`ifdef BIN_CAPTURE_PEAK_EN
    ,
    output logic [LOGN-1:0] peak_bin,
    output logic [2*DW:0]   peak_mag2
`endif
);

    typedef enum logic {W_FILL, W_DROP} wstate_t;

    wstate_t         state, state_n;
    logic [LOGN-1:0] wr_cnt, wr_cnt_n;
    logic            wr_bank, wr_bank_n;
    logic            wr_sel;
    logic            frame_start;
    logic            do_write;
    logic            frame_done;
    logic            sync_err_n;
    logic            overrun_n;
    logic [1:0]      full, full_n;
    logic [1:0]      vis;
    logic            rd_bank;
    logic            release_ok;
    logic [2*DW-1:0] rd_word;

    logic [2*DW-1:0] mem [0:2*N-1];

    assign frame_ready = vis[rd_bank];
    assign release_ok  = rd_release & frame_ready;
    assign frame_start = (wr_cnt == '0);

    // A new frame goes into the read bank when that bank is empty, so the
    // read pointer always names the oldest frame; otherwise into the other.
    assign wr_sel = frame_start ? (full[rd_bank] ? ~rd_bank : rd_bank) : wr_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= W_FILL;
            wr_cnt   <= '0;
            wr_bank  <= 1'b0;
            full     <= 2'b00;
            vis      <= 2'b00;
            rd_bank  <= 1'b0;
            sync_err <= 1'b0;
            overrun  <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_n;
            wr_cnt   <= wr_cnt_n;
            wr_bank  <= wr_bank_n;
            full     <= full_n;
            // A bank becomes visible to the reader one cycle after it fills,
            // and disappears in the same cycle it is released.
            vis      <= full & full_n;
            rd_bank  <= release_ok ? ~rd_bank : rd_bank;
            sync_err <= sync_err_n;
            overrun  <= overrun_n;
            rd_valid <= rd_en & frame_ready;
        end
    end

    always_comb begin
        state_n    = state;
        wr_cnt_n   = wr_cnt;
        wr_bank_n  = wr_bank;
        do_write   = 1'b0;
        frame_done = 1'b0;
        sync_err_n = 1'b0;
        overrun_n  = 1'b0;
        case (state)
            W_FILL: begin
                if (s_valid) begin
                    if (frame_start && (full == 2'b11)) begin
                        overrun_n = 1'b1;
                        if (!s_last) begin
                            state_n = W_DROP;
                        end
                    end else begin
                        do_write  = 1'b1;
                        wr_bank_n = wr_sel;
                        if (s_last && (wr_cnt == LOGN'(N-1))) begin
                            frame_done = 1'b1;
                            wr_cnt_n   = '0;
                        end else if (s_last || (wr_cnt == LOGN'(N-1))) begin
                            sync_err_n = 1'b1;
                            wr_cnt_n   = '0;
                        end else begin
                            wr_cnt_n = wr_cnt + 1'b1;
                        end
                    end
                end
            end
            W_DROP: begin
                // Return to W_FILL at the end of the dropped frame; the first
                // beat of the next frame re-checks bank availability, so a
                // still-full buffer drops it too and pulses overrun again.
                if (s_valid && s_last) begin
                    state_n = W_FILL;
                end
            end
            default: state_n = W_FILL;
        endcase
    end

    always_comb begin
        full_n = full;
        if (release_ok) begin
            full_n[rd_bank] = 1'b0;
        end
        if (frame_done) begin
            full_n[wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[{wr_sel, wr_cnt}] <= {s_re, s_im};
        end
        if (rd_en) begin
            rd_word <= mem[{rd_bank, rd_addr}];
        end
    end

    assign rd_re = rd_valid ? rd_word[2*DW-1:DW] : '0;
    assign rd_im = rd_valid ? rd_word[DW-1:0]    : '0;

`ifdef BIN_CAPTURE_PEAK_EN
    logic signed [2*DW-1:0] re_ext, im_ext;
    logic        [2*DW-1:0] re_sq, im_sq;
    logic        [2*DW:0]   mag;
    logic        [LOGN-1:0] pk_bin0, pk_bin1;
    logic        [2*DW:0]   pk_mag0, pk_mag1;
    logic        [2*DW:0]   pk_cur;

    assign re_ext = {{DW{s_re[DW-1]}}, s_re};
    assign im_ext = {{DW{s_im[DW-1]}}, s_im};
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;
    assign mag    = {1'b0, re_sq} + {1'b0, im_sq};
    assign pk_cur = wr_sel ? pk_mag1 : pk_mag0;

    // Strict compare keeps the lowest bin on ties; the first beat of a frame
    // always overwrites whatever a discarded partial frame left behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pk_bin0 <= '0;
            pk_bin1 <= '0;
            pk_mag0 <= '0;
            pk_mag1 <= '0;
        end else if (do_write && (frame_start || (mag > pk_cur))) begin
            if (wr_sel) begin
                pk_bin1 <= wr_cnt;
                pk_mag1 <= mag;
            end else begin
                pk_bin0 <= wr_cnt;
                pk_mag0 <= mag;
            end
        end
    end

    assign peak_bin  = frame_ready ? (rd_bank ? pk_bin1 : pk_bin0) : '0;
    assign peak_mag2 = frame_ready ? (rd_bank ? pk_mag1 : pk_mag0) : '0;
`endif

endmodule
